instr_fetch_ctrl: RTL

- Fetch sequencer between the CPU core and the instruction ROM/memory bus.
- Owns the fetch PC, which starts at the MIPS reset vector, and issues word reads with a read/waitrequest handshake.
- Presents each fetched instruction to decode through a valid/ready handshake, and handles branch/jump redirects.
- Raises a sticky fault on misaligned or out-of-range fetch addresses.

---
 rtl/instr_fetch_ctrl_if.sv | 25 ++
 rtl/instr_fetch_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction memory read port, decode handshake,
// redirect input and fault flag, grouped for the controller (master) and its environment (slave).
interface instr_fetch_ctrl_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_fault;

  modport master (
    output mem_address, mem_read, instr_valid, instr_word, instr_pc, fetch_fault,
    input  mem_waitrequest, mem_readdata, instr_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  mem_address, mem_read, instr_valid, instr_word, instr_pc, fetch_fault,
    output mem_waitrequest, mem_readdata, instr_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues word reads with waitrequest,
// hands words to decode via valid/ready, services redirects and latches a sticky fault.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] ROM_BASE     = 32'hBFC00000,
  parameter int unsigned ROM_BYTES    = 256
) (
  input  logic               clk,
  input  logic               reset_n,
  instr_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;

  localparam logic [31:0] ROM_LAST = ROM_BASE + 32'(ROM_BYTES) - 32'd4;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] word_q, word_nxt;
  logic [31:0] ipc_q, ipc_nxt;
  logic        redir_pend, redir_pend_nxt;
  logic [31:0] redir_tgt, redir_tgt_nxt;

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= ROM_BASE) && (a <= ROM_LAST);
  endfunction

  function automatic state_t enter(input logic [31:0] a);
    return legal(a) ? REQ : FAULT;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      word_q     <= '0;
      ipc_q      <= '0;
      redir_pend <= 1'b0;
      redir_tgt  <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      word_q     <= word_nxt;
      ipc_q      <= ipc_nxt;
      redir_pend <= redir_pend_nxt;
      redir_tgt  <= redir_tgt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    word_nxt       = word_q;
    ipc_nxt        = ipc_q;
    redir_pend_nxt = redir_pend;
    redir_tgt_nxt  = redir_tgt;
    unique case (state)
      IDLE: begin
        if (bus.redirect_valid) pc_nxt = bus.redirect_target;
        state_nxt = enter(pc_nxt);
      end
      REQ: begin
        // The bus address must stay put while stalled, so a redirect is parked until acceptance.
        if (bus.mem_waitrequest) begin
          if (bus.redirect_valid) begin
            redir_pend_nxt = 1'b1;
            redir_tgt_nxt  = bus.redirect_target;
          end
        end else if (bus.redirect_valid) begin
          pc_nxt         = bus.redirect_target;
          redir_pend_nxt = 1'b0;
          state_nxt      = enter(pc_nxt);
        end else if (redir_pend) begin
          pc_nxt         = redir_tgt;
          redir_pend_nxt = 1'b0;
          state_nxt      = enter(pc_nxt);
        end else begin
          word_nxt  = bus.mem_readdata;
          ipc_nxt   = pc;
          pc_nxt    = pc + 32'd4;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          pc_nxt    = bus.redirect_target;
          state_nxt = enter(pc_nxt);
        end else if (bus.instr_ready) begin
          state_nxt = enter(pc);
        end
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem_address = pc;
  assign bus.mem_read    = (state == REQ);
  assign bus.instr_valid = (state == HOLD);
  assign bus.fetch_fault = (state == FAULT);
  assign bus.instr_word  = word_q;
  assign bus.instr_pc    = ipc_q;

endmodule
